// File: rtl/asteroid_pkg.sv
// Shared types and dimensions for the asteroid-dodging game sequencer.
// The player-grid helper lives here so that every consumer places the player the same way.
package asteroid_pkg;
    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int SCORE_W = 8;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } state_t;

    // The player only ever occupies the bottom row.
    function automatic grid_t player_grid(input logic [3:0] col);
        grid_t g;
        g = '0;
        g[ROWS-1][col] = 1'b1;
        return g;
    endfunction
endpackage

// File: rtl/collisionCheck.sv
// 16x16 OR-reduce collision detector.
// The input is the bitwise AND of the asteroid field and the player grid.
module collisionCheck
    import asteroid_pkg::*;
(
    input  logic [ROWS-1:0][COLS-1:0] overlap,
    output logic                      hit
);
    assign hit = |overlap;
endmodule

// File: rtl/game_sequencer.sv
// Asteroid-field game sequencer: the field shifts down every SPEED ticks and the player moves along the bottom row.
// Any tick or applied move is followed by a one-cycle collision check.
module game_sequencer
    import asteroid_pkg::*;
#(
    parameter int SPEED     = 4,
    parameter int START_COL = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      left,
    input  logic                      right,
    input  logic [COLS-1:0]           spawn_row,
    output logic [ROWS-1:0][COLS-1:0] asteroids,
    output logic [ROWS-1:0][COLS-1:0] player,
    output logic                      running,
    output logic                      game_over,
    output logic [SCORE_W-1:0]        score
);
    localparam logic [3:0]         START_COL_L = 4'(START_COL);
    localparam logic [3:0]         LAST_CNT    = 4'(SPEED - 1);
    localparam logic [3:0]         MAX_COL     = 4'(COLS - 1);
    localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    state_t             state_r, state_s;
    grid_t              asteroids_r, asteroids_s;
    grid_t              player_r, player_s;
    logic [3:0]         col_r, col_s;
    logic [3:0]         cnt_r, cnt_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic               running_r, running_s;
    logic               game_over_r, game_over_s;
    logic               hit_s;
    logic               mv_left_s, mv_right_s;

    collisionCheck u_collision (
        .overlap (asteroids_r & player_r),
        .hit     (hit_s)
    );

    // Moves against a wall, or both directions at once, are not applied.
    assign mv_left_s  = left & ~right & (col_r != MAX_COL);
    assign mv_right_s = right & ~left & (col_r != 4'd0);

    // Next-state, grid, counter and score logic.
    always_comb begin
        state_s     = state_r;
        asteroids_s = asteroids_r;
        player_s    = player_r;
        col_s       = col_r;
        cnt_s       = cnt_r;
        score_s     = score_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    score_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (tick) begin
                    if (cnt_r == LAST_CNT) begin
                        asteroids_s = {asteroids_r[ROWS-2:0], spawn_row};
                        cnt_s       = 4'd0;
                        score_s     = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_ONE;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
                if (mv_left_s) begin
                    col_s = col_r + 4'd1;
                end else if (mv_right_s) begin
                    col_s = col_r - 4'd1;
                end else begin
                    col_s = col_r;
                end
                player_s = player_grid(col_s);
                if (tick || mv_left_s || mv_right_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = RUN;
                end
            end
            CHECK: begin
                state_s = hit_s ? OVER : RUN;
            end
            OVER: begin
                if (start) begin
                    state_s     = IDLE;
                    asteroids_s = '0;
                    col_s       = START_COL_L;
                    player_s    = player_grid(START_COL_L);
                    cnt_s       = 4'd0;
                end else begin
                    state_s = OVER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        running_s   = (state_s == RUN) || (state_s == CHECK);
        game_over_s = (state_s == OVER);
    end

    // All sequencer state, with the status flags registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            asteroids_r <= '0;
            player_r    <= player_grid(START_COL_L);
            col_r       <= START_COL_L;
            cnt_r       <= 4'd0;
            score_r     <= '0;
            running_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            asteroids_r <= asteroids_s;
            player_r    <= player_s;
            col_r       <= col_s;
            cnt_r       <= cnt_s;
            score_r     <= score_s;
            running_r   <= running_s;
            game_over_r <= game_over_s;
        end
    end

    assign asteroids = asteroids_r;
    assign player    = player_r;
    assign running   = running_r;
    assign game_over = game_over_r;
    assign score     = score_r;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a row-array game model predicts every cycle's outputs,
// and a monitor compares them one clock after the stimulus is applied.
module tb_game_sequencer;
    localparam int SPEED     = 4;
    localparam int START_COL = 7;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_CHECK = 2;
    localparam int P_OVER  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic tick = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0;
    logic [15:0] spawn_row = 16'h0000;
    logic [15:0][15:0] asteroids, player;
    logic running, game_over;
    logic [7:0] score;

    typedef struct {
        logic [15:0][15:0] ast;
        logic [15:0][15:0] ply;
        logic              run;
        logic              go;
        logic [7:0]        sc;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mrows[16];
    int mcol, mcnt, mscore, mphase;

    game_sequencer #(.SPEED(SPEED), .START_COL(START_COL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .start     (start),
        .left      (left),
        .right     (right),
        .spawn_row (spawn_row),
        .asteroids (asteroids),
        .player    (player),
        .running   (running),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input exp_t e);
        bit bad;
        bad = 1'b0;
        vectors++;
        if (asteroids !== e.ast) begin
            $display("FAIL %s asteroids: got %h expected %h", tag, asteroids, e.ast);
            bad = 1'b1;
        end
        if (player !== e.ply) begin
            $display("FAIL %s player: got %h expected %h", tag, player, e.ply);
            bad = 1'b1;
        end
        if (running !== e.run) begin
            $display("FAIL %s running: got %b expected %b", tag, running, e.run);
            bad = 1'b1;
        end
        if (game_over !== e.go) begin
            $display("FAIL %s game_over: got %b expected %b", tag, game_over, e.go);
            bad = 1'b1;
        end
        if (score !== e.sc) begin
            $display("FAIL %s score: got %0d expected %0d", tag, score, e.sc);
            bad = 1'b1;
        end
        if (bad) miscompares++;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        for (int r = 0; r < 16; r++) e.ast[r] = mrows[r];
        e.ply = '0;
        e.ply[15][mcol] = 1'b1;
        e.run = (mphase == P_RUN) || (mphase == P_CHECK);
        e.go  = (mphase == P_OVER);
        e.sc  = 8'(mscore);
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) mrows[r] = 16'h0000;
        mcol   = START_COL;
        mcnt   = 0;
        mscore = 0;
        mphase = P_IDLE;
    endtask

    // Game rules applied to the inputs present at the coming clock edge.
    task automatic model_step();
        bit moved;
        if (!reset_n) begin
            model_reset();
        end else begin
            case (mphase)
                P_IDLE: if (start) begin
                    mphase = P_RUN;
                    mscore = 0;
                end
                P_RUN: begin
                    moved = 1'b0;
                    if (left && !right && mcol < 15) begin
                        mcol++;
                        moved = 1'b1;
                    end else if (right && !left && mcol > 0) begin
                        mcol--;
                        moved = 1'b1;
                    end
                    if (tick) begin
                        mcnt++;
                        if (mcnt == SPEED) begin
                            for (int r = 15; r > 0; r--) mrows[r] = mrows[r-1];
                            mrows[0] = spawn_row;
                            mcnt = 0;
                            if (mscore < 255) mscore++;
                        end
                    end
                    if (tick || moved) mphase = P_CHECK;
                end
                P_CHECK: mphase = mrows[15][mcol] ? P_OVER : P_RUN;
                P_OVER: if (start) begin
                    for (int r = 0; r < 16; r++) mrows[r] = 16'h0000;
                    mcol   = START_COL;
                    mcnt   = 0;
                    mphase = P_IDLE;
                end
                default: mphase = P_IDLE;
            endcase
        end
    endtask

    task automatic step(input logic t, input logic s, input logic l, input logic r, input logic [15:0] sp);
        @(negedge clk);
        tick = t; start = s; left = l; right = r; spawn_row = sp;
        model_step();
        sbq.push_back(model_exp());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic do_tick(input logic [15:0] sp);
        step(1'b1, 1'b0, 1'b0, 1'b0, sp);
        idle();
    endtask

    task automatic do_shift(input logic [15:0] sp);
        repeat (SPEED - 1) do_tick(16'h0000);
        do_tick(sp);
    endtask

    task automatic move(input logic l, input logic r);
        step(1'b0, 1'b0, l, r, 16'h0000);
        idle();
    endtask

    // Reset lands between clock edges, so the IDLE values must show without any edge.
    task automatic do_reset(input int hold);
        @(negedge clk);
        tick = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0; spawn_row = 16'h0000;
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare("async_reset", model_exp());
        repeat (hold) idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: one expected snapshot per applied cycle.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            compare("cycle", e);
        end
    end

    initial begin
        logic t, s, l, r;
        #1 reset_n = 1'b0;
        #1 model_reset();
        compare("power_on_reset", model_exp());
        repeat (3) idle();
        @(negedge clk);
        reset_n = 1'b1;

        // First game: four ticks give one shift with spawn 0x0001.
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (SPEED) do_tick(16'h0001);

        // Walk to the left wall, push past it, then press both directions.
        repeat (8) move(1'b1, 1'b0);
        repeat (3) move(1'b1, 1'b0);
        move(1'b1, 1'b1);

        // Drop a column-7 asteroid onto the player by shifting alone.
        repeat (8) move(1'b0, 1'b1);
        do_shift(16'h0080);
        repeat (15) do_shift(16'h0000);
        repeat (2) idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        repeat (2) idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Step sideways onto a resting column-6 asteroid, then reset while in OVER.
        do_shift(16'h0040);
        repeat (15) do_shift(16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        repeat (3) idle();
        do_reset(2);

        // Reset mid-count in RUN, then reset in CHECK.
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        do_tick(16'h0000);
        do_tick(16'h0000);
        do_reset(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_reset(1);

        // Score saturation over 260 empty shifts.
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (260) do_shift(16'h0000);
        idle();

        // Random play with occasional resets.
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 2));
            end else begin
                t = ($urandom_range(0, 2) == 0);
                s = ($urandom_range(0, 29) == 0);
                l = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) == 0);
                step(t, s, l, r, 16'($urandom & $urandom & $urandom));
            end
        end

        idle();
        @(posedge clk);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
